// File: rtl/mem_access_unit_if.sv
// Load/store request, data-memory bus and writeback signals of mem_access_unit.
// The slave modport is the unit itself; master is whoever drives requests and models the bus.
interface mem_access_unit_if #(
  parameter int pXLEN       = 32,
  parameter int pRegSelBitW = 5
);
  logic                   iReqValid;
  logic                   oReqReady;
  logic                   iReqRead;
  logic                   iReqWrite;
  logic [pXLEN-1:0]       iReqAddr;
  logic [pXLEN-1:0]       iReqData;
  logic [2:0]             iReqOpType;
  logic [pRegSelBitW-1:0] iReqRdAddr;

  logic                   oMemReq;
  logic                   oMemWe;
  logic [pXLEN-1:0]       oMemAddr;
  logic [pXLEN-1:0]       oMemWData;
  logic [pXLEN/8-1:0]     oMemBe;
  logic                   iMemAck;
  logic [pXLEN-1:0]       iMemRData;

  logic                   oRegDv;
  logic [pRegSelBitW-1:0] oRegAddr;
  logic [pXLEN-1:0]       oRegData;
  logic                   oMisaligned;
  logic                   oIllegal;
  logic                   oBusErr;

  modport slave (
    input  iReqValid, iReqRead, iReqWrite, iReqAddr, iReqData, iReqOpType, iReqRdAddr,
    input  iMemAck, iMemRData,
    output oReqReady, oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe,
    output oRegDv, oRegAddr, oRegData, oMisaligned, oIllegal, oBusErr
  );

  modport master (
    output iReqValid, iReqRead, iReqWrite, iReqAddr, iReqData, iReqOpType, iReqRdAddr,
    output iMemAck, iMemRData,
    input  oReqReady, oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe,
    input  oRegDv, oRegAddr, oRegData, oMisaligned, oIllegal, oBusErr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: one op at a time on a req/ack word bus; load result 1 cycle after ack, store idle 1 cycle after ack.
// Backpressure: oReqReady is low from acceptance until the op finishes; the bus may stall until the timeout.
module mem_access_unit #(
  parameter int          pXLEN          = 32,
  parameter int          pRegSelBitW    = 5,
  parameter int unsigned pTimeoutCycles = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  mem_access_unit_if.slave bus
);
  localparam int               cBeW     = pXLEN / 8;
  localparam logic [31:0]      cTimeout = 32'(pTimeoutCycles);
  localparam logic [cBeW-1:0]  cBeOne   = cBeW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [pXLEN-1:0]       addr_q, addr_d, data_q, data_d;
  logic [2:0]             op_q, op_d;
  logic                   wr_q, wr_d;
  logic [pRegSelBitW-1:0] rd_q, rd_d;
  logic [31:0]            cnt_q, cnt_d;

  logic                   ready_q, ready_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [pXLEN-1:0]       mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [cBeW-1:0]        mem_be_q, mem_be_d;
  logic                   reg_dv_q, reg_dv_d;
  logic [pRegSelBitW-1:0] reg_addr_q, reg_addr_d;
  logic [pXLEN-1:0]       reg_data_q, reg_data_d;
  logic                   misal_q, misal_d, illegal_q, illegal_d, bus_err_q, bus_err_d;

  logic                   accept, req_bad, req_misal, load_done, timed_out;
  logic                   op_legal, addr_misal;
  logic [pXLEN-1:0]       rshift, ext;

  assign accept = bus.iReqValid && ready_q;

  // op[2] marks unsigned loads, which stores do not have
  assign op_legal   = (bus.iReqOpType[1:0] != 2'b11) &&
                      !(bus.iReqOpType[2] && (bus.iReqOpType[1] || bus.iReqWrite));
  assign addr_misal = ((bus.iReqOpType[1:0] == 2'b01) && bus.iReqAddr[0]) ||
                      ((bus.iReqOpType[1:0] == 2'b10) && (bus.iReqAddr[1:0] != 2'b00));

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      op_q        <= '0;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      reg_dv_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      misal_q     <= 1'b0;
      illegal_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      op_q        <= op_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      reg_dv_q    <= reg_dv_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      misal_q     <= misal_d;
      illegal_q   <= illegal_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    op_d      = op_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    req_bad   = 1'b0;
    req_misal = 1'b0;
    load_done = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = bus.iReqAddr;
          data_d = bus.iReqData;
          op_d   = bus.iReqOpType;
          wr_d   = bus.iReqWrite;
          rd_d   = bus.iReqRdAddr;
          cnt_d  = '0;
          if ((bus.iReqRead == bus.iReqWrite) || !op_legal) begin
            req_bad = 1'b1;
          end else if (addr_misal) begin
            req_misal = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // an ack on the final allowed cycle still wins over the timeout
        if (bus.iMemAck) begin
          state_d   = wr_q ? IDLE : RESP;
          load_done = !wr_q;
        end else if ((cTimeout != 32'd0) && (cnt_q + 32'd1 == cTimeout)) begin
          state_d   = IDLE;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d     = (state_d == IDLE);
    mem_req_d   = (state_d == REQ);
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_be_d    = '0;
    if (state_d == REQ) begin
      mem_we_d   = wr_d;
      mem_addr_d = {addr_d[pXLEN-1:2], 2'b00};
      mem_be_d   = '1;
      if (wr_d) begin
        case (op_d[1:0])
          2'b00: begin
            mem_be_d    = cBeOne << addr_d[1:0];
            mem_wdata_d = {(pXLEN/8){data_d[7:0]}};
          end
          2'b01: begin
            mem_be_d    = addr_d[1] ? cBeW'(4'b1100) : cBeW'(4'b0011);
            mem_wdata_d = {(pXLEN/16){data_d[15:0]}};
          end
          default: mem_wdata_d = data_d;
        endcase
      end
    end

    rshift = bus.iMemRData >> {addr_q[1:0], 3'b000};
    case (op_q)
      3'b000:  ext = {{(pXLEN-8){rshift[7]}}, rshift[7:0]};
      3'b001:  ext = {{(pXLEN-16){rshift[15]}}, rshift[15:0]};
      3'b100:  ext = {{(pXLEN-8){1'b0}}, rshift[7:0]};
      3'b101:  ext = {{(pXLEN-16){1'b0}}, rshift[15:0]};
      default: ext = rshift;
    endcase

    reg_dv_d   = load_done && (rd_q != '0);
    reg_addr_d = load_done ? rd_q : '0;
    reg_data_d = load_done ? ext : '0;
    misal_d    = req_misal;
    illegal_d  = req_bad;
    bus_err_d  = timed_out;
  end

  assign bus.oReqReady   = ready_q;
  assign bus.oMemReq     = mem_req_q;
  assign bus.oMemWe      = mem_we_q;
  assign bus.oMemAddr    = mem_addr_q;
  assign bus.oMemWData   = mem_wdata_q;
  assign bus.oMemBe      = mem_be_q;
  assign bus.oRegDv      = reg_dv_q;
  assign bus.oRegAddr    = reg_addr_q;
  assign bus.oRegData    = reg_data_q;
  assign bus.oMisaligned = misal_q;
  assign bus.oIllegal    = illegal_q;
  assign bus.oBusErr     = bus_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, rejects, bus timeout and reset during a request.
module tb_mem_access_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_access_unit_if #(.pXLEN(32), .pRegSelBitW(5)) bus ();

  mem_access_unit #(
    .pXLEN(32),
    .pRegSelBitW(5),
    .pTimeoutCycles(8)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one request for a single edge, then drop valid
  task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rdsel);
    bus.iReqValid  = 1'b1;
    bus.iReqRead   = rd;
    bus.iReqWrite  = wr;
    bus.iReqOpType = op;
    bus.iReqAddr   = addr;
    bus.iReqData   = data;
    bus.iReqRdAddr = rdsel;
    tick();
    bus.iReqValid  = 1'b0;
    bus.iReqRead   = 1'b0;
    bus.iReqWrite  = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] word);
    bus.iMemAck   = 1'b1;
    bus.iMemRData = word;
    tick();
    bus.iMemAck   = 1'b0;
    bus.iMemRData = 32'h0;
  endtask

  initial begin
    int n;
    int dv_seen;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.iReqValid  = 1'b0;
    bus.iReqRead   = 1'b0;
    bus.iReqWrite  = 1'b0;
    bus.iReqAddr   = 32'h0;
    bus.iReqData   = 32'h0;
    bus.iReqOpType = 3'b000;
    bus.iReqRdAddr = 5'd0;
    bus.iMemAck    = 1'b0;
    bus.iMemRData  = 32'h0;
    tick();
    tick();
    check("rst_ready", 32'(bus.oReqReady), 32'd1);
    check("rst_memreq", 32'(bus.oMemReq), 32'd0);
    check("rst_dv", 32'(bus.oRegDv), 32'd0);
    check("rst_flags", {29'd0, bus.oMisaligned, bus.oIllegal, bus.oBusErr}, 32'd0);
    rst = 1'b1;
    tick();

    // LB at 0x1003, zero-wait ack
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5);
    check("lb_req", 32'(bus.oMemReq), 32'd1);
    check("lb_addr", bus.oMemAddr, 32'h0000_1000);
    check("lb_be", 32'(bus.oMemBe), 32'hF);
    check("lb_we", 32'(bus.oMemWe), 32'd0);
    check("lb_ready", 32'(bus.oReqReady), 32'd0);
    ack_now(32'h80AB_CDEF);
    check("lb_dv", 32'(bus.oRegDv), 32'd1);
    check("lb_data", bus.oRegData, 32'hFFFF_FF80);
    check("lb_rd", 32'(bus.oRegAddr), 32'd5);
    check("lb_req_drop", 32'(bus.oMemReq), 32'd0);
    tick();
    check("lb_dv_pulse", 32'(bus.oRegDv), 32'd0);
    check("lb_ready_back", 32'(bus.oReqReady), 32'd1);

    // LHU at 0x2002 with three wait cycles
    issue(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd7);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("lhu_req_c%0d", i), 32'(bus.oMemReq), 32'd1);
      check($sformatf("lhu_addr_c%0d", i), bus.oMemAddr, 32'h0000_2000);
      if (i < 4) tick();
    end
    ack_now(32'hBEEF_1234);
    check("lhu_dv", 32'(bus.oRegDv), 32'd1);
    check("lhu_data", bus.oRegData, 32'h0000_BEEF);
    tick();

    // SB at 0x1001
    issue(1'b0, 1'b1, 3'b000, 32'h0000_1001, 32'h1234_56A5, 5'd0);
    check("sb_we", 32'(bus.oMemWe), 32'd1);
    check("sb_be", 32'(bus.oMemBe), 32'h2);
    check("sb_wdata", bus.oMemWData, 32'hA5A5_A5A5);
    ack_now(32'h0);
    check("sb_ready", 32'(bus.oReqReady), 32'd1);
    check("sb_no_dv", 32'(bus.oRegDv), 32'd0);
    check("sb_req_drop", 32'(bus.oMemReq), 32'd0);

    // SH at 0x1002 uses the upper half lanes
    issue(1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h0000_BEEF, 5'd0);
    check("sh_be", 32'(bus.oMemBe), 32'hC);
    check("sh_wdata", bus.oMemWData, 32'hBEEF_BEEF);
    ack_now(32'h0);

    // LH at 0x1000 with rd=0: bus read happens but no writeback
    issue(1'b1, 1'b0, 3'b001, 32'h0000_1000, 32'h0, 5'd0);
    check("lh_rd0_req", 32'(bus.oMemReq), 32'd1);
    ack_now(32'h0000_8001);
    check("lh_rd0_no_dv", 32'(bus.oRegDv), 32'd0);
    tick();

    // rejects: misaligned word, bad funct3, read+write both set
    issue(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 5'd1);
    check("mis_pulse", 32'(bus.oMisaligned), 32'd1);
    check("mis_no_req", 32'(bus.oMemReq), 32'd0);
    check("mis_ready", 32'(bus.oReqReady), 32'd1);
    tick();
    check("mis_pulse_end", 32'(bus.oMisaligned), 32'd0);
    issue(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'h0, 5'd1);
    check("ill_f3", 32'(bus.oIllegal), 32'd1);
    check("ill_f3_no_req", 32'(bus.oMemReq), 32'd0);
    tick();
    issue(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'h0, 5'd1);
    check("ill_rw", 32'(bus.oIllegal), 32'd1);
    tick();

    // LW with no ack: timeout after 8 request cycles
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd2);
    n = 0;
    dv_seen = 0;
    while (bus.oMemReq && n < 20) begin
      n++;
      if (bus.oBusErr) dv_seen++;
      tick();
    end
    check("to_req_cycles", 32'(n), 32'd8);
    check("to_err_early", 32'(dv_seen), 32'd0);
    check("to_buserr", 32'(bus.oBusErr), 32'd1);
    check("to_no_dv", 32'(bus.oRegDv), 32'd0);
    check("to_ready", 32'(bus.oReqReady), 32'd1);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 5'd3);
    check("to_next_req", 32'(bus.oMemReq), 32'd1);
    check("to_err_pulse", 32'(bus.oBusErr), 32'd0);
    ack_now(32'h1122_3344);
    check("to_next_data", bus.oRegData, 32'h1122_3344);
    tick();

    // reset during REQ, then a late ack that must be ignored
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd9);
    tick();
    check("rr_req", 32'(bus.oMemReq), 32'd1);
    rst = 1'b0;
    tick();
    check("rr_req_drop", 32'(bus.oMemReq), 32'd0);
    check("rr_ready", 32'(bus.oReqReady), 32'd1);
    rst = 1'b1;
    ack_now(32'hDEAD_BEEF);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.oRegDv || bus.oMemReq) n++;
      tick();
    end
    check("rr_late_ack", 32'(n), 32'd0);
    check("rr_ready_end", 32'(bus.oReqReady), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
